// File: rtl/button_event_fifo.sv
// button_event_fifo: debounced, edge-detected buttons queued as timestamped events behind a register bus
module button_event_fifo #(
   parameter int NUM_BUTTONS = 8,
   parameter int FIFO_DEPTH  = 16,
   parameter int DEBOUNCE_W  = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_BUTTONS-1:0] butoes,
   input  logic                   we,
   input  logic                   rd,
   input  logic [2:0]             register_addr,
   input  logic [31:0]            wr_data,
   output logic [31:0]            rd_data,
   output logic                   ready,
   output logic                   irq
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int HW = NUM_BUTTONS > 1 ? $clog2(NUM_BUTTONS) : 1;

   logic [NUM_BUTTONS-1:0]   s1, s2, stable, stable_d, pending, noise_en, rise, fall, qual, head_oh;
   logic [2*NUM_BUTTONS-1:0] edge_sel;
   logic [DEBOUNCE_W-1:0]    debounce;
   logic [DEBOUNCE_W-1:0]    cnt [NUM_BUTTONS];
   logic [24:0]              pdata [NUM_BUTTONS];
   logic [28:0]              mem [FIFO_DEPTH];
   logic [28:0]              head_entry;
   logic [AW-1:0]            wptr, rptr;
   logic [8:0]               count;
   logic [23:0]              ts;
   logic [HW-1:0]            head;
   logic [31:0]              rdata;
   logic enable, irq_en, clr_q, overflow, empty, full, rd_en, wr_ctrl, pop, push_req, push, ovf_set;
   logic unused;

   assign unused = ^wr_data;

   always_comb begin
      empty   = count == '0;
      full    = count == 9'(FIFO_DEPTH);
      rd_en   = rd & ~we;
      wr_ctrl = we & (register_addr == 3'd1);
      pop     = rd_en & (register_addr == 3'd5) & ~empty;
      rise    = stable & ~stable_d;
      fall    = ~stable & stable_d;
      head    = '0;
      qual    = '0;
      for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
         head    = pending[i] ? HW'(i) : head;
         qual[i] = enable & ((rise[i] & edge_sel[2*i]) | (fall[i] & edge_sel[2*i+1]));
      end
      push_req   = |pending;
      push       = push_req & (~full | pop);
      head_oh    = push_req ? NUM_BUTTONS'(1) << head : '0;
      // an edge landing on the entry being drained this cycle is not an overwrite
      ovf_set    = |(qual & pending & ~head_oh) | (push_req & ~push);
      head_entry = {pdata[head][24], 4'(head), pdata[head][23:0]};
   end

   always_comb begin
      case (register_addr)
         3'd0:    rdata = {20'd0, overflow, full, empty, count};
         3'd1:    rdata = {28'd0, irq_en, 2'b00, enable};
         3'd2:    rdata = 32'(edge_sel);
         3'd3:    rdata = 32'(debounce);
         3'd4:    rdata = 32'(noise_en);
         3'd5:    rdata = empty ? '0 : {1'b1, mem[rptr][28], 2'b00, mem[rptr][27:0]};
         3'd6:    rdata = 32'(stable);
         default: rdata = {8'd0, ts};
      endcase
   end

   always_ff @(posedge clk)
      if (push) mem[wptr] <= head_entry;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         {s1, s2, stable, stable_d, pending, noise_en} <= '0;
         for (int i = 0; i < NUM_BUTTONS; i++) begin
            cnt[i]   <= '0;
            pdata[i] <= '0;
         end
         edge_sel <= '0;
         debounce <= '0;
         {wptr, rptr, count, ts} <= '0;
         {enable, irq_en, clr_q, overflow, ready, irq} <= '0;
         rd_data  <= '0;
      end else begin
         ts       <= ts + 1'b1;
         s1       <= butoes;
         s2       <= s1;
         stable_d <= stable;
         for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (noise_en[i] && debounce != '0) begin
               if (s2[i] == stable[i]) cnt[i] <= '0;
               else if (cnt[i] == debounce) begin
                  stable[i] <= s2[i];
                  cnt[i]    <= '0;
               end else cnt[i] <= cnt[i] + 1'b1;
            end else begin
               stable[i] <= s2[i];
               cnt[i]    <= '0;
            end
            if (qual[i]) begin
               pending[i] <= 1'b1;
               pdata[i]   <= {rise[i], ts};
            end else if (head_oh[i]) pending[i] <= 1'b0;
         end
         if (push) wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
         count <= count + 9'(push) - 9'(pop);
         if (clr_q) begin
            pending <= '0;
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
         end
         overflow <= ovf_set | (overflow & ~(wr_ctrl & wr_data[2]));
         clr_q    <= wr_ctrl & wr_data[1];
         if (wr_ctrl) begin
            enable <= wr_data[0];
            irq_en <= wr_data[3];
         end
         if (we && register_addr == 3'd2) edge_sel <= wr_data[2*NUM_BUTTONS-1:0];
         if (we && register_addr == 3'd3) debounce <= wr_data[DEBOUNCE_W-1:0];
         if (we && register_addr == 3'd4) noise_en <= wr_data[NUM_BUTTONS-1:0];
         ready <= we | rd;
         irq   <= irq_en & ~empty;
         if (rd_en) rd_data <= rdata;
      end
   end
endmodule

// File: tb/tb_button_event_fifo.sv
// tb_button_event_fifo: directed and randomized checks against an event-queue model
module tb_button_event_fifo;
   logic        clk = 1'b0, rst = 1'b0, we = 1'b0, rd = 1'b0;
   logic [7:0]  butoes = '0;
   logic [2:0]  register_addr = '0;
   logic [31:0] wr_data = '0;
   logic [31:0] rd_data;
   logic        ready, irq;

   int          vectors = 0, miscompares = 0;
   int unsigned cyc;
   int unsigned c0;
   logic [7:0]  lv = '0;
   logic [15:0] m_sel = '0;
   logic        m_en = 1'b0, m_ovf = 1'b0;
   logic [31:0] q[$];
   logic [31:0] r;

   button_event_fifo dut (
      .clk(clk), .rst(rst), .butoes(butoes), .we(we), .rd(rd),
      .register_addr(register_addr), .wr_data(wr_data),
      .rd_data(rd_data), .ready(ready), .irq(irq)
   );

   always #5 clk = ~clk;

   // cycles since reset release; equals the DUT timestamp between edges
   always @(posedge clk or negedge rst)
      if (!rst) cyc <= 0;
      else cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      vectors++;
      assert (obs === want) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, want);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_until(input int unsigned target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      we = 1'b1; register_addr = a; wr_data = d;
      @(negedge clk);
      we = 1'b0;
   endtask

   task automatic rd_check(input string tag, input logic [2:0] a, input logic [31:0] want);
      rd = 1'b1; register_addr = a;
      @(negedge clk);
      rd = 1'b0;
      check(tag, rd_data, want);
   endtask

   function automatic logic [31:0] status_exp();
      int n;
      n = q.size();
      return 32'(n) | (n == 0 ? 32'h200 : 32'h0) | (n == 16 ? 32'h400 : 32'h0) | (m_ovf ? 32'h800 : 32'h0);
   endfunction

   // bypass path: an edge is stamped three cycles after the input changes
   task automatic change(input logic [7:0] nl);
      for (int i = 0; i < 8; i++)
         if (nl[i] != lv[i] && m_en && m_sel[2*i + (nl[i] ? 0 : 1)]) begin
            if (q.size() < 16) q.push_back({1'b1, nl[i], 2'b00, 4'(i), 24'(cyc + 3)});
            else m_ovf = 1'b1;
         end
      lv = nl;
      butoes = nl;
   endtask

   task automatic pop_check(input string tag);
      logic [31:0] want;
      want = '0;
      if (q.size() != 0) want = q.pop_front();
      rd_check(tag, 3'd5, want);
   endtask

   initial begin
      tick(3);
      check("reset_rd_data", rd_data, 32'h0);
      check("reset_irq", 32'(irq), 32'h0);
      check("reset_ready", 32'(ready), 32'h0);
      rst = 1'b1;
      rd_check("reset_status", 3'd0, 32'h200);
      rd_check("reset_ctrl", 3'd1, 32'h0);
      rd_check("reset_event", 3'd5, 32'h0);

      wr(3'd2, 32'h1); wr(3'd4, 32'h1); wr(3'd3, 32'd4); wr(3'd1, 32'h1);
      m_en = 1'b1; m_sel = 16'h1;
      c0 = cyc; lv[0] = 1'b1; butoes = lv;
      wait_until(c0 + 6);
      rd_check("db_level_early", 3'd6, 32'h0);
      rd_check("db_level_late", 3'd6, 32'h1);
      tick(5);
      rd_check("db_status", 3'd0, 32'h1);
      rd_check("db_event", 3'd5, {1'b1, 1'b1, 2'b00, 4'd0, 24'(c0 + 7)});
      rd_check("db_empty", 3'd0, 32'h200);

      wr(3'd3, 32'd10); wr(3'd4, 32'h3); wr(3'd2, 32'h4);
      m_sel = 16'h4;
      for (int k = 0; k < 10; k++) begin
         lv[1] = ~lv[1]; butoes = lv; tick(3);
      end
      c0 = cyc; lv[1] = 1'b1; butoes = lv;
      tick(20);
      rd_check("bounce_count", 3'd0, 32'h1);
      rd_check("bounce_event", 3'd5, {1'b1, 1'b1, 2'b00, 4'd1, 24'(c0 + 13)});
      rd_check("bounce_drained", 3'd5, 32'h0);

      wr(3'd2, 32'h0); m_sel = 16'h0; wr(3'd4, 32'h0);
      change(8'h00); tick(6);
      wr(3'd2, 32'hFFFF); m_sel = 16'hFFFF;
      change(8'h89); tick(8);
      rd_check("simul_status", 3'd0, status_exp());
      repeat (3) pop_check("simul_event");

      for (int n = 0; n < 20; n++) begin
         if (n % 5 == 0) begin
            m_sel = 16'($urandom);
            wr(3'd2, 32'(m_sel));
         end
         change(lv ^ 8'($urandom_range(1, 255)));
         tick(14);
         rd_check("rand_status", 3'd0, status_exp());
         while (q.size() != 0) pop_check("rand_event");
         pop_check("rand_drained");
      end

      wr(3'd2, 32'hFFFF); m_sel = 16'hFFFF;
      for (int k = 0; k < 17; k++) begin
         change(lv ^ 8'h01); tick(4);
      end
      tick(6);
      rd_check("ovf_status", 3'd0, status_exp());
      for (int k = 0; k < 17; k++) pop_check("ovf_event");
      rd_check("ovf_sticky", 3'd0, status_exp());
      wr(3'd1, 32'h5); m_ovf = 1'b0;
      rd_check("ovf_cleared", 3'd0, status_exp());

      wr(3'd1, 32'h9);
      c0 = cyc;
      change(lv ^ 8'h01);
      wait_until(c0 + 5);
      check("irq_before_push", 32'(irq), 32'h0);
      tick(1);
      check("irq_after_push", 32'(irq), 32'h1);
      pop_check("irq_event");
      tick(1);
      check("irq_after_pop", 32'(irq), 32'h0);
      change(lv ^ 8'h09); tick(8);
      check("irq_two_queued", 32'(irq), 32'h1);
      rd_check("two_status", 3'd0, status_exp());
      wr(3'd1, 32'hB);
      check("clr_ready", 32'(ready), 32'h1);
      tick(1);
      check("clr_ready_once", 32'(ready), 32'h0);
      q.delete();
      tick(1);
      check("clr_irq", 32'(irq), 32'h0);
      rd_check("clr_status", 3'd0, status_exp());
      rd_check("ctrl_readback", 3'd1, 32'h9);

      we = 1'b1; rd = 1'b1; register_addr = 3'd3; wr_data = 32'd7;
      @(negedge clk);
      we = 1'b0; rd = 1'b0;
      check("both_ready", 32'(ready), 32'h1);
      check("both_rd_held", rd_data, 32'h9);
      tick(1);
      check("both_ready_once", 32'(ready), 32'h0);
      rd_check("both_wrote", 3'd3, 32'd7);

      change(lv ^ 8'h89); tick(8);
      rd_check("pre_reset_status", 3'd0, status_exp());
      #2 rst = 1'b0;
      #1;
      check("async_rd_data", rd_data, 32'h0);
      check("async_irq", 32'(irq), 32'h0);
      check("async_ready", 32'(ready), 32'h0);
      q.delete(); m_ovf = 1'b0; m_sel = '0; m_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      rd_check("post_reset_status", 3'd0, 32'h200);
      rd_check("post_reset_event", 3'd5, 32'h0);
      rd_check("post_reset_ctrl", 3'd1, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
